fde_datapath: RTL and testbench

FDE_DATAPATH -- requirements
Module: fde_datapath

---
 rtl/fde_datapath.sv | 154 +++++++++++++++
 tb/tb_fde_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fde_datapath.sv
// Four-register 8-bit datapath stepped by external fetch/decode/execute strobes.
// Define FDE_SEQ_CHECK_EN to add an f->d->e phase-order tracker.
module fde_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f,
    input  logic        d,
    input  logic        e,
    input  logic [15:0] imem_rdata,
    output logic [7:0]  imem_addr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        halted,
    output logic        zero,
    output logic        seq_err
);
    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpMov  = 4'h7;
    localparam logic [3:0] OpJmp  = 4'h8;
    localparam logic [3:0] OpJz   = 4'h9;
    localparam logic [3:0] OpOut  = 4'hA;
    localparam logic [3:0] OpHalt = 4'hF;

    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [7:0]  regs [4];

    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [1:0]  strobe_cnt;
    logic        multi_hot;
    logic        single_hot;
    logic        phase_ok;
    logic        order_err;
    logic        do_f;
    logic        do_d;
    logic        do_e;
    logic [7:0]  result;
    logic        writes_rd;
    logic        sets_zero;

    assign opcode    = ir[15:12];
    assign rd        = ir[11:10];
    assign rs        = ir[9:8];
    assign imm       = ir[7:0];
    assign imem_addr = pc;

    // Strobe-free cycles are legal idle cycles; only multi-hot strobes are errors.
    assign strobe_cnt = {1'b0, f} + {1'b0, d} + {1'b0, e};
    assign multi_hot  = (strobe_cnt > 2'd1);
    assign single_hot = (strobe_cnt == 2'd1);

`ifdef FDE_SEQ_CHECK_EN
    typedef enum logic [1:0] {PhFetch, PhDecode, PhExec} phase_e;
    phase_e phase;

    assign phase_ok = (f && phase == PhFetch) || (d && phase == PhDecode) ||
                      (e && phase == PhExec);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= PhFetch;
        end else if (do_f) begin
            phase <= PhDecode;
        end else if (do_d) begin
            phase <= PhExec;
        end else if (do_e) begin
            phase <= PhFetch;
        end
    end
`else
    assign phase_ok = 1'b1;
`endif

    assign order_err = !halted && single_hot && !phase_ok;
    assign do_f      = !halted && single_hot && phase_ok && f;
    assign do_d      = !halted && single_hot && phase_ok && d;
    assign do_e      = !halted && single_hot && phase_ok && e;

    always_comb begin
        result    = 8'h00;
        writes_rd = 1'b1;
        sets_zero = 1'b0;
        case (opcode)
            OpLdi: result = imm;
            OpAdd: begin result = opa + opb; sets_zero = 1'b1; end
            OpSub: begin result = opa - opb; sets_zero = 1'b1; end
            OpAnd: begin result = opa & opb; sets_zero = 1'b1; end
            OpOr:  begin result = opa | opb; sets_zero = 1'b1; end
            OpXor: begin result = opa ^ opb; sets_zero = 1'b1; end
            OpMov: result = opb;
            default: writes_rd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= 8'h00;
            ir        <= 16'h0000;
            opa       <= 8'h00;
            opb       <= 8'h00;
            regs      <= '{default: 8'h00};
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            zero      <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!halted && (multi_hot || order_err)) begin
                seq_err <= 1'b1;
            end
            if (do_f) begin
                ir <= imem_rdata;
                pc <= pc + 8'd1;
            end
            if (do_d) begin
                opa <= regs[rd];
                opb <= regs[rs];
            end
            if (do_e) begin
                if (writes_rd) begin
                    regs[rd] <= result;
                end
                if (sets_zero) begin
                    zero <= (result == 8'h00);
                end
                case (opcode)
                    OpJmp: pc <= imm;
                    OpJz: begin
                        if (zero) begin
                            pc <= imm;
                        end
                    end
                    OpOut: begin
                        out_data  <= opb;
                        out_valid <= 1'b1;
                    end
                    OpHalt: halted <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fde_datapath.sv
// Directed self-checking bench for fde_datapath with hand-assembled programs.
module tb_fde_datapath;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        f;
    logic        d;
    logic        e;
    logic [15:0] imem_rdata;
    logic [7:0]  imem_addr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        halted;
    logic        zero;
    logic        seq_err;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fde_datapath dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f          (f),
        .d          (d),
        .e          (e),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted),
        .zero       (zero),
        .seq_err    (seq_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [2:0] fde);
        @(negedge clk);
        {f, d, e} = fde;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr();
        strobe(3'b100);
        strobe(3'b010);
        strobe(3'b001);
    endtask

    // Reset lasts one edge; strobes may be held alongside it to test priority.
    task automatic apply_reset(input logic [2:0] fde);
        @(negedge clk);
        rst_n = 1'b0;
        {f, d, e} = fde;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {f, d, e} = 3'b000;
    endtask

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0;
        {f, d, e} = 3'b000;
        clear_mem();

        // Reset values
        apply_reset(3'b000);
        check("rst_addr", {8'h00, imem_addr}, 16'h0000);
        check("rst_out_data", {8'h00, out_data}, 16'h0000);
        check("rst_out_valid", {15'h0, out_valid}, 16'h0000);
        check("rst_halted", {15'h0, halted}, 16'h0000);
        check("rst_zero", {15'h0, zero}, 16'h0000);
        check("rst_seq_err", {15'h0, seq_err}, 16'h0000);

        // LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0
        mem[0] = 16'h1005;
        mem[1] = 16'h1403;
        mem[2] = 16'h2100;
        mem[3] = 16'hA000;
        for (int i = 0; i < 3; i++) run_instr();
        strobe(3'b100);
        strobe(3'b010);
        check("out_valid_pre_e", {15'h0, out_valid}, 16'h0000);
        strobe(3'b001);
        check("out_data_8", {8'h00, out_data}, 16'h0008);
        check("out_valid_pulse", {15'h0, out_valid}, 16'h0001);
        check("zero_after_add", {15'h0, zero}, 16'h0000);
        check("pc_after_4", {8'h00, imem_addr}, 16'h0004);
        check("seq_err_clean", {15'h0, seq_err}, 16'h0000);
        strobe(3'b000);
        check("out_valid_idle", {15'h0, out_valid}, 16'h0000);
        check("out_data_hold", {8'h00, out_data}, 16'h0008);

        // LDI r2,7; SUB r2,r2; JZ 0x40 (taken); then a not-taken JZ
        apply_reset(3'b000);
        clear_mem();
        mem[8'h00] = 16'h1807;
        mem[8'h01] = 16'h3A00;
        mem[8'h02] = 16'h9040;
        mem[8'h40] = 16'h1C01;
        mem[8'h41] = 16'h2F00;
        mem[8'h42] = 16'h9010;
        for (int i = 0; i < 3; i++) run_instr();
        check("zero_after_sub", {15'h0, zero}, 16'h0001);
        check("jz_taken", {8'h00, imem_addr}, 16'h0040);
        run_instr();
        check("zero_held_ldi", {15'h0, zero}, 16'h0001);
        run_instr();
        check("zero_after_add2", {15'h0, zero}, 16'h0000);
        run_instr();
        check("jz_not_taken", {8'h00, imem_addr}, 16'h0043);

        // JMP 0xFF, fetch at 0xFF wraps pc, then ADD 0xFF+0x01
        apply_reset(3'b000);
        clear_mem();
        mem[8'h00] = 16'h1401;
        mem[8'h01] = 16'h80FF;
        mem[8'hFF] = 16'h10FF;
        run_instr();
        run_instr();
        check("jmp_ff", {8'h00, imem_addr}, 16'h00FF);
        strobe(3'b100);
        check("pc_wrap", {8'h00, imem_addr}, 16'h0000);
        strobe(3'b010);
        strobe(3'b001);
        mem[8'h00] = 16'h2100;
        mem[8'h01] = 16'hA000;
        run_instr();
        check("add_wrap_zero", {15'h0, zero}, 16'h0001);
        run_instr();
        check("add_wrap_result", {8'h00, out_data}, 16'h0000);
        check("add_wrap_valid", {15'h0, out_valid}, 16'h0001);

        // Logic ops, MOV, unused opcode, then HALT
        apply_reset(3'b000);
        clear_mem();
        mem[0]  = 16'h10CC;
        mem[1]  = 16'h14AA;
        mem[2]  = 16'h7800;
        mem[3]  = 16'h4900;
        mem[4]  = 16'hA200;
        mem[5]  = 16'h6100;
        mem[6]  = 16'h5100;
        mem[7]  = 16'hB000;
        mem[8]  = 16'hA000;
        mem[9]  = 16'hF000;
        mem[10] = 16'h1000;
        mem[11] = 16'hA000;
        for (int i = 0; i < 5; i++) run_instr();
        check("and_mov_out", {8'h00, out_data}, 16'h0088);
        for (int i = 0; i < 4; i++) run_instr();
        check("xor_or_out", {8'h00, out_data}, 16'h00EE);
        check("zero_logic", {15'h0, zero}, 16'h0000);
        run_instr();
        check("halted_set", {15'h0, halted}, 16'h0001);
        check("halt_pc", {8'h00, imem_addr}, 16'h000A);
        for (int i = 0; i < 3; i++) run_instr();
        check("halt_pc_frozen", {8'h00, imem_addr}, 16'h000A);
        check("halt_still", {15'h0, halted}, 16'h0001);
        check("halt_out_frozen", {8'h00, out_data}, 16'h00EE);
        check("halt_no_valid", {15'h0, out_valid}, 16'h0000);
        apply_reset(3'b000);
        check("post_halt_addr", {8'h00, imem_addr}, 16'h0000);
        check("post_halt_halted", {15'h0, halted}, 16'h0000);
        check("post_halt_out", {8'h00, out_data}, 16'h0000);
        check("post_halt_zero", {15'h0, zero}, 16'h0000);

        // Reset during decode of ADD r0,r1 abandons it and clears r0
        clear_mem();
        mem[0] = 16'h1005;
        mem[1] = 16'h1403;
        mem[2] = 16'h2100;
        run_instr();
        run_instr();
        strobe(3'b100);
        apply_reset(3'b010);
        check("rst_mid_addr", {8'h00, imem_addr}, 16'h0000);
        mem[0] = 16'h2000;
        run_instr();
        check("rst_mid_r0_zero", {15'h0, zero}, 16'h0001);
        check("rst_mid_fetch0", {8'h00, imem_addr}, 16'h0001);

        // Multi-hot strobe: no state change, sticky error
        apply_reset(3'b000);
        clear_mem();
        strobe(3'b110);
        check("multi_hot_pc", {8'h00, imem_addr}, 16'h0000);
        check("multi_hot_err", {15'h0, seq_err}, 16'h0001);
        strobe(3'b100);
        check("seq_err_sticky", {15'h0, seq_err}, 16'h0001);

`ifdef FDE_SEQ_CHECK_EN
        // f then e: e ignored; the following f is also out of order
        apply_reset(3'b000);
        mem[0] = 16'h1009;
        mem[1] = 16'hA000;
        strobe(3'b100);
        strobe(3'b001);
        check("order_err", {15'h0, seq_err}, 16'h0001);
        strobe(3'b100);
        check("order_f_ignored", {8'h00, imem_addr}, 16'h0001);
        strobe(3'b010);
        strobe(3'b001);
        run_instr();
        check("order_resume_out", {8'h00, out_data}, 16'h0009);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
